// File: rtl/flag_table_multiport.sv
// Valid-flag table for the hashtable pipelines: 2**SIZE rows of BUCKET_SIZE flag bits, NUM_READ
// registered read ports with full/first-free decode, masked writes, clear sweep and occupancy count.
// Optional FLAG_TABLE_WR_BYPASS_EN: when defined, reads of the row being written return the new value.
module flag_table_multiport #(
    parameter  int SIZE        = 10,
    parameter  int BUCKET_SIZE = 4,
    parameter  int NUM_READ    = 3,
    localparam int IDX_W       = (BUCKET_SIZE == 1) ? 1 : $clog2(BUCKET_SIZE),
    localparam int CNT_W       = SIZE + IDX_W + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_req,
    input  logic [NUM_READ*SIZE-1:0]        read_adr,
    input  logic [SIZE-1:0]                 write_adr,
    input  logic                            write_en,
    input  logic [BUCKET_SIZE-1:0]          write_mask,
    input  logic [BUCKET_SIZE-1:0]          write_val,
    output logic                            ready,
    output logic [NUM_READ*BUCKET_SIZE-1:0] flag_out,
    output logic [NUM_READ-1:0]             full_out,
    output logic [NUM_READ*IDX_W-1:0]       free_idx_out,
    output logic [CNT_W-1:0]                occupancy
);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        sweep_adr_q, sweep_adr_d;
    logic                   sweep_we;
    logic                   write_go;
    logic                   clear_go;

    logic [BUCKET_SIZE-1:0] mem [2**SIZE];
    logic [BUCKET_SIZE-1:0] old_row;
    logic [BUCKET_SIZE-1:0] new_row;
    logic [BUCKET_SIZE-1:0] rd_row [NUM_READ];

    function automatic logic [CNT_W-1:0] popcount(input logic [BUCKET_SIZE-1:0] row);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < BUCKET_SIZE; b++) begin
            cnt = cnt + CNT_W'(row[b]);
        end
        return cnt;
    endfunction

    // Scanning from the top down leaves the lowest clear slot; a full row yields 0.
    function automatic logic [IDX_W-1:0] first_free(input logic [BUCKET_SIZE-1:0] row);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int b = BUCKET_SIZE - 1; b >= 0; b--) begin
            if (!row[b]) begin
                idx = IDX_W'(b);
            end
        end
        return idx;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SWEEP;
            sweep_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_adr_q <= sweep_adr_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sweep_adr_d = sweep_adr_q;
        sweep_we    = 1'b0;
        write_go    = 1'b0;
        clear_go    = 1'b0;
        case (state_q)
            SWEEP: begin
                sweep_we    = 1'b1;
                sweep_adr_d = sweep_adr_q + SIZE'(1);
                if (&sweep_adr_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d     = SWEEP;
                    sweep_adr_d = '0;
                    clear_go    = 1'b1;
                end else if (write_en) begin
                    write_go = 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    assign ready = (state_q == IDLE);

    assign old_row = mem[write_adr];
    assign new_row = (old_row & ~write_mask) | (write_val & write_mask);

    // NOTE: the flag array has no reset branch; the sweep FSM clears it row by row instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_we) begin
                mem[sweep_adr_q] <= '0;
            end else if (write_go) begin
                mem[write_adr] <= new_row;
            end
        end
    end

    // Difference of popcounts cannot underflow the total, so modular arithmetic is exact here.
    always_ff @(posedge clk) begin
        if (reset || clear_go) begin
            occupancy <= '0;
        end else if (write_go) begin
            occupancy <= occupancy + popcount(new_row) - popcount(old_row);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            rd_row[i] = mem[read_adr[i*SIZE +: SIZE]];
`ifdef FLAG_TABLE_WR_BYPASS_EN
            if (write_go && (read_adr[i*SIZE +: SIZE] == write_adr)) begin
                rd_row[i] = new_row;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !ready) begin
            flag_out     <= '0;
            full_out     <= '0;
            free_idx_out <= '0;
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                flag_out[i*BUCKET_SIZE +: BUCKET_SIZE] <= rd_row[i];
                full_out[i]                            <= &rd_row[i];
                free_idx_out[i*IDX_W +: IDX_W]         <= first_free(rd_row[i]);
            end
        end
    end

endmodule

// File: tb/tb_flag_table_multiport.sv
// Directed bench for flag_table_multiport at SIZE=4, BUCKET_SIZE=4, NUM_READ=3.
// Same-cycle read/write expectations follow FLAG_TABLE_WR_BYPASS_EN.
module tb_flag_table_multiport;

    localparam int SIZE  = 4;
    localparam int BS    = 4;
    localparam int NR    = 3;
    localparam int IDX_W = 2;
    localparam int CNT_W = SIZE + IDX_W + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear_req;
    logic [NR*SIZE-1:0]   read_adr;
    logic [SIZE-1:0]      write_adr;
    logic                 write_en;
    logic [BS-1:0]        write_mask;
    logic [BS-1:0]        write_val;
    logic                 ready;
    logic [NR*BS-1:0]     flag_out;
    logic [NR-1:0]        full_out;
    logic [NR*IDX_W-1:0]  free_idx_out;
    logic [CNT_W-1:0]     occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    flag_table_multiport #(
        .SIZE(SIZE),
        .BUCKET_SIZE(BS),
        .NUM_READ(NR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear_req(clear_req),
        .read_adr(read_adr),
        .write_adr(write_adr),
        .write_en(write_en),
        .write_mask(write_mask),
        .write_val(write_val),
        .ready(ready),
        .flag_out(flag_out),
        .full_out(full_out),
        .free_idx_out(free_idx_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input int adr);
        read_adr[port*SIZE +: SIZE] = SIZE'(adr);
    endtask

    task automatic do_write(input int adr, input logic [BS-1:0] mask, input logic [BS-1:0] val);
        write_adr  = SIZE'(adr);
        write_mask = mask;
        write_val  = val;
        write_en   = 1'b1;
        cycle();
        write_en   = 1'b0;
    endtask

    function automatic logic [BS-1:0] flag_of(input int port);
        return flag_out[port*BS +: BS];
    endfunction

    function automatic logic [IDX_W-1:0] free_of(input int port);
        return free_idx_out[port*IDX_W +: IDX_W];
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cycle();
            n++;
        end
    endtask

    logic [BS-1:0]    exp_same;
    logic [IDX_W-1:0] exp_same_free;
    int               n;

    initial begin
`ifdef FLAG_TABLE_WR_BYPASS_EN
        exp_same      = 4'b0001;
        exp_same_free = 2'd1;
`else
        exp_same      = 4'b0000;
        exp_same_free = 2'd0;
`endif
        reset = 1'b1; clear_req = 1'b0; read_adr = '0;
        write_adr = '0; write_en = 1'b0; write_mask = '0; write_val = '0;
        cycle();
        cycle();
        check("reset_ready", ready, 0);
        check("reset_occ", occupancy, 0);
        check("reset_flags", flag_out, 0);
        check("reset_full", full_out, 0);
        check("reset_free", free_idx_out, 0);

        reset = 1'b0;
        wait_ready(n);
        check("init_sweep_len", n, 16);
        check("init_occ", occupancy, 0);

        for (int r = 0; r < 16; r++) begin
            set_rd(r % NR, r);
            cycle();
            check($sformatf("init_row%0d", r), flag_of(r % NR), 0);
        end
        check("init_full", full_out, 0);
        check("init_free", free_idx_out, 0);

        do_write(5, 4'b1111, 4'b0101);
        set_rd(2, 5);
        cycle();
        check("w1_flag", flag_of(2), 4'b0101);
        check("w1_free", free_of(2), 1);
        check("w1_full", full_out[2], 0);
        check("w1_occ", occupancy, 2);

        do_write(5, 4'b1010, 4'b1010);
        set_rd(0, 5); set_rd(1, 5); set_rd(2, 5);
        cycle();
        check("w2_flags_shared", flag_out, 12'hfff);
        check("w2_full", full_out, 3'b111);
        check("w2_free", free_idx_out, 0);
        check("w2_occ", occupancy, 4);

        set_rd(0, 3);
        do_write(3, 4'b0001, 4'b0001);
        check("same_cycle_flag", flag_of(0), exp_same);
        check("same_cycle_free", free_of(0), exp_same_free);
        cycle();
        check("after_write_flag", flag_of(0), 4'b0001);
        check("after_write_free", free_of(0), 1);
        check("same_cycle_occ", occupancy, 5);

        do_write(5, 4'b0000, 4'b0000);
        set_rd(1, 5);
        cycle();
        check("mask0_flag", flag_of(1), 4'b1111);
        check("mask0_occ", occupancy, 5);

        do_write(5, 4'b0100, 4'b0000);
        cycle();
        check("clr_bit_flag", flag_of(1), 4'b1011);
        check("clr_bit_free", free_of(1), 2);
        check("clr_bit_occ", occupancy, 4);

        do_write(12, 4'b1111, 4'b1110);
        set_rd(1, 12);
        cycle();
        check("r12_flag", flag_of(1), 4'b1110);
        check("r12_free", free_of(1), 0);
        check("r12_full", full_out[1], 0);
        check("r12_occ", occupancy, 7);
        do_write(12, 4'b1111, 4'b0000);
        check("r12_clear_occ", occupancy, 4);

        do_write(9, 4'b1111, 4'b0111);
        set_rd(2, 9);
        cycle();
        check("r9_free", free_of(2), 3);
        check("pre_clear_occ", occupancy, 7);

        clear_req = 1'b1;
        do_write(0, 4'b1111, 4'b1111);
        clear_req = 1'b0;
        check("clear_ready", ready, 0);
        check("clear_occ", occupancy, 0);
        set_rd(0, 9);
        n = 0;
        while (!ready && n < 100) begin
            write_en   = (n == 4);
            clear_req  = (n == 4);
            write_adr  = '0;
            write_mask = 4'b1111;
            write_val  = 4'b1111;
            cycle();
            n++;
            if (n == 2) check("sweep_flag_zero", flag_of(0), 0);
        end
        write_en = 1'b0; clear_req = 1'b0;
        check("clear_sweep_len", n, 16);
        check("post_clear_occ", occupancy, 0);
        for (int r = 0; r < 16; r++) begin
            set_rd(0, r);
            cycle();
            check($sformatf("post_clear_row%0d", r), flag_of(0), 0);
        end

        do_write(2, 4'b1111, 4'b1111);
        check("pre_rst_occ", occupancy, 4);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (8) cycle();
        reset = 1'b1;
        cycle();
        check("midsweep_rst_ready", ready, 0);
        check("midsweep_rst_occ", occupancy, 0);
        check("midsweep_rst_flags", flag_out, 0);
        reset = 1'b0;
        wait_ready(n);
        check("midsweep_rst_len", n, 16);
        set_rd(1, 2);
        cycle();
        check("post_rst_row2", flag_of(1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
